// File: rtl/i2c_bit_sampler_if.sv
// Bus bundle between the I2C bit sampler and its consumer: raw pad inputs plus the
// per-bit strobes and frame status produced from them.
interface i2c_bit_sampler_if;
  logic       scl_in;
  logic       sda_in;
  logic       bit_out;
  logic       bit_en;
  logic       ack_bit;
  logic       ack_valid;
  logic       byte_done;
  logic       start_det;
  logic       stop_det;
  logic [3:0] bit_cnt;
  logic       busy;

  modport master (
    input  scl_in, sda_in,
    output bit_out, bit_en, ack_bit, ack_valid, byte_done, start_det, stop_det, bit_cnt, busy
  );

  modport slave (
    output scl_in, sda_in,
    input  bit_out, bit_en, ack_bit, ack_valid, byte_done, start_det, stop_det, bit_cnt, busy
  );
endinterface

// File: rtl/i2c_bit_sampler.sv
// I2C receive front end: synchronises SCL/SDA, detects START/STOP and emits per-bit strobes.
// Optional glitch filter on the synchronised lines is enabled by I2C_GLITCH_FILTER_EN.
module i2c_bit_sampler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input logic               clk,
  input logic               rst_n,
  i2c_bit_sampler_if.master bus
);

  typedef enum logic {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl_f, sda_f, scl_d, sda_d;
  logic start, stop, scl_rise;
  state_e state_q, state_d;

  logic       bit_out_q, bit_out_d, bit_en_q, bit_en_d;
  logic       ack_bit_q, ack_bit_d, ack_valid_q, ack_valid_d;
  logic       byte_done_q, byte_done_d, start_det_q, start_det_d, stop_det_q, stop_det_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;

  // Preset to 1 so reset looks like an idle bus and cannot fake a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic [CntW-1:0] scl_cnt_q, sda_cnt_q;
  logic            scl_f_q, sda_f_q;

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      if (scl_s == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CntMax) begin
        scl_f_q   <= scl_s;
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + CntW'(1);
      end
      if (sda_s == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CntMax) begin
        sda_f_q   <= sda_s;
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + CntW'(1);
      end
    end
  end

  assign scl_f = scl_f_q;
  assign sda_f = sda_f_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign start    = scl_f & scl_d & sda_d & ~sda_f;
  assign stop     = scl_f & scl_d & ~sda_d & sda_f;
  assign scl_rise = scl_f & ~scl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_out_q   <= 1'b0;
      bit_en_q    <= 1'b0;
      ack_bit_q   <= 1'b0;
      ack_valid_q <= 1'b0;
      byte_done_q <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      bit_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      bit_out_q   <= bit_out_d;
      bit_en_q    <= bit_en_d;
      ack_bit_q   <= ack_bit_d;
      ack_valid_q <= ack_valid_d;
      byte_done_q <= byte_done_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StActive;
      StActive: if (stop && !start) state_d = StIdle;
    endcase
  end

  always_comb begin
    bit_out_d   = bit_out_q;
    ack_bit_d   = ack_bit_q;
    bit_en_d    = 1'b0;
    ack_valid_d = 1'b0;
    byte_done_d = 1'b0;
    start_det_d = start;
    stop_det_d  = stop;
    bit_cnt_d   = bit_cnt_q;
    if (start) begin
      bit_cnt_d = 4'd0;
    end else if (state_q == StActive) begin
      if (stop) begin
        bit_cnt_d = 4'd0;
      end else if (scl_rise) begin
        if (bit_cnt_q < 4'd8) begin
          bit_out_d   = sda_f;
          bit_en_d    = 1'b1;
          byte_done_d = (bit_cnt_q == 4'd7);
          bit_cnt_d   = bit_cnt_q + 4'd1;
        end else begin
          ack_bit_d   = sda_f;
          ack_valid_d = 1'b1;
          bit_cnt_d   = 4'd0;
        end
      end
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_en    = bit_en_q;
  assign bus.ack_bit   = ack_bit_q;
  assign bus.ack_valid = ack_valid_q;
  assign bus.byte_done = byte_done_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.busy      = (state_q == StActive);

endmodule
